branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
// - Execute-stage consumer of the decode-stage branch prediction (shouldTakeBranch).
// - Carries pc/is_branch/prediction from decode into execute and compares the prediction with the actual outcome.
// - Drives the past_* feedback ports of the branch predictor.
// - On a mispredict, drives the fetch redirect and squashes the wrong-path decode slots.
// PARAMETERS
// - PC_INC        1   fall-through increment (word-addressed PC)
// - FLUSH_CYCLES  2   wrong-path slots squashed per mispredict (>=1)
// - CNT_W         16  width of the statistics counters
// PORTS
// - clock                 in   1      single clock; rising edge
// - reset                 in   1      asynchronous, active-low; clears all state
// - stall                 in   1      pipeline hold; X register keeps contents
// - dx_valid              in   1      decode slot holds a real instruction
// - dx_pc                 in   32     pc of decode instruction
// - dx_is_branch          in   1      decode instruction is a branch
// - dx_predicted_taken    in   1      predictor's shouldTakeBranch for dx_pc
// - ex_taken              in   1      actual branch condition for X entry (combinational from ALU)
// - ex_target             in   32     actual branch target for X entry
// - past_pc               out  32     pc of last resolved branch (to predictor)
// - past_is_branch        out  1      1-cycle pulse: a branch resolved last cycle
// - past_predicted_taken  out  1      prediction carried with that branch
// - past_wrong            out  1      that branch was mispredicted
// - redirect_valid        out  1      1-cycle pulse: fetch must load redirect_pc
// - redirect_pc           out  32     correct next pc
// - flush                 out  1      squash fetch/decode this cycle
// - branch_count          out  CNT_W  resolved branches, saturating
// - mispredict_count      out  CNT_W  mispredicts, saturating
// BEHAVIOUR
// - Reset (reset=0, async): every output 0, X register invalid, FSM=IDLE, counters 0.
// - X register: at an edge with stall=0, loads {dx_valid & ~kill, dx_pc, dx_is_branch, dx_predicted_taken}.
//   - With stall=1 it holds.
//   - kill = mispredict | (state==FLUSH).
// - resolve = x_valid & x_is_branch & ~stall.
//   - A stalled entry resolves once, on the cycle stall drops.
// - mispredict (combinational) = resolve & (ex_taken != x_predicted_taken).
// - Outputs registered at the edge ending the resolve cycle (1-cycle latency):
//   - past_is_branch <= resolve; past_pc, past_predicted_taken, past_wrong load only when resolve=1, else past_wrong <= 0.
//   - redirect_valid <= mispredict.
//   - redirect_pc <= ex_taken ? ex_target : x_pc + PC_INC (32-bit wrap).
// - FSM IDLE/FLUSH, counter fcnt:
//   - IDLE & mispredict -> FLUSH, fcnt = FLUSH_CYCLES-1; if FLUSH_CYCLES==1, stay IDLE.
//   - FLUSH: fcnt decrements each non-stalled cycle; at 0 -> IDLE.
//   - flush output = mispredict | (state==FLUSH), combinational.
//   - X entries loaded under kill are bubbles, so no second mispredict can arise while in FLUSH.
// - Non-branch or invalid X entries: no past_* pulse, no redirect, counters unchanged.
// - Counters: branch_count += resolve; mispredict_count += mispredict; both hold at 2^CNT_W-1.
// - Simultaneous stall & mispredict condition: no action until stall=0.
// TESTING
// - Reset mid-FLUSH: FSM=IDLE, flush=0, counters 0, X invalid immediately (asynchronous).
// - Correct prediction: branch pc=0x10, predicted 1, ex_taken=1, target 0x40.
//   - Next cycle: past_is_branch=1, past_pc=0x10, past_wrong=0, redirect_valid=0; branch_count=1.
// - Predicted taken, actually not-taken: pc=0x20, pred=1, ex_taken=0.
//   - flush=1 in resolve cycle; next cycle redirect_valid=1, redirect_pc=0x21, past_wrong=1.
//   - flush high 2 cycles total; the 2 following dx slots never reach X.
// - Predicted not-taken, actually taken: pc=0x30, pred=0, ex_target=0x80.
//   - redirect_pc=0x80, mispredict_count=1.
// - Stall over resolving branch for 3 cycles: exactly one past_is_branch pulse and one count, after stall drops.
// - CNT_W=2, 5 resolved branches: branch_count saturates at 3.
// - pc=0xFFFFFFFF not-taken mispredict: redirect_pc=0x00000000.

Source files
------------

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: compares the decode-time prediction with the
// ALU outcome, feeds the predictor history ports and redirects fetch on a mispredict.
module branch_resolver #(
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             dx_valid,
    input  logic [31:0]      dx_pc,
    input  logic             dx_is_branch,
    input  logic             dx_predicted_taken,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [31:0]      past_pc,
    output logic             past_is_branch,
    output logic             past_predicted_taken,
    output logic             past_wrong,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             state_dbg
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    // Handshake: dx_valid qualifies the decode slot; there is no ready, stall is the
    // only backpressure and freezes the X register and the flush countdown.
    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              x_valid_q, x_valid_d;
    logic [31:0]       x_pc_q, x_pc_d;
    logic              x_is_branch_q, x_is_branch_d;
    logic              x_pred_q, x_pred_d;
    logic [31:0]       past_pc_q, past_pc_d;
    logic              past_is_branch_q, past_is_branch_d;
    logic              past_pred_q, past_pred_d;
    logic              past_wrong_q, past_wrong_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

    logic resolve, mispredict, kill;

    assign resolve    = x_valid_q & x_is_branch_q & ~stall;
    assign mispredict = resolve & (ex_taken != x_pred_q);
    assign kill       = mispredict | (state_q == FLUSH);

    always_comb begin
        x_valid_d     = x_valid_q;
        x_pc_d        = x_pc_q;
        x_is_branch_d = x_is_branch_q;
        x_pred_d      = x_pred_q;
        if (!stall) begin
            x_valid_d     = dx_valid & ~kill;
            x_pc_d        = dx_pc;
            x_is_branch_d = dx_is_branch;
            x_pred_d      = dx_predicted_taken;
        end
    end

    always_comb begin
        past_is_branch_d   = resolve;
        past_pc_d          = past_pc_q;
        past_pred_d        = past_pred_q;
        past_wrong_d       = 1'b0;
        redirect_valid_d   = mispredict;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve) begin
            past_pc_d    = x_pc_q;
            past_pred_d  = x_pred_q;
            past_wrong_d = mispredict;
            if (branch_count_q != {CNT_W{1'b1}})
                branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (mispredict) begin
            redirect_pc_d = ex_taken ? ex_target : x_pc_q + 32'(PC_INC);
            if (mispredict_count_q != {CNT_W{1'b1}})
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    // The resolve cycle itself is the first flush cycle, so FLUSH lasts FLUSH_CYCLES-1.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict && FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = FW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (fcnt_q <= FW'(1)) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            fcnt_q             <= '0;
            x_valid_q          <= 1'b0;
            x_pc_q             <= '0;
            x_is_branch_q      <= 1'b0;
            x_pred_q           <= 1'b0;
            past_pc_q          <= '0;
            past_is_branch_q   <= 1'b0;
            past_pred_q        <= 1'b0;
            past_wrong_q       <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            fcnt_q             <= fcnt_d;
            x_valid_q          <= x_valid_d;
            x_pc_q             <= x_pc_d;
            x_is_branch_q      <= x_is_branch_d;
            x_pred_q           <= x_pred_d;
            past_pc_q          <= past_pc_d;
            past_is_branch_q   <= past_is_branch_d;
            past_pred_q        <= past_pred_d;
            past_wrong_q       <= past_wrong_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign past_pc              = past_pc_q;
    assign past_is_branch       = past_is_branch_q;
    assign past_predicted_taken = past_pred_q;
    assign past_wrong           = past_wrong_q;
    assign redirect_valid       = redirect_valid_q;
    assign redirect_pc          = redirect_pc_q;
    assign flush                = kill;
    assign branch_count         = branch_count_q;
    assign mispredict_count     = mispredict_count_q;
    assign state_dbg            = state_q;

endmodule
